// File: rtl/counter_checker.sv
// counter_checker: passive monitor for an up/down counter.
// Samples the observed counter value and direction every clock, locks onto
// the sequence, predicts each next value and flags deviations. Reports
// wrap-around events and keeps a saturating mismatch count.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   en       observed counter active (0 forces IDLE)
//   mode     observed counter direction: 1 = up, 0 = down
//   cnt_in   observed counter value
//   locked   high while in LOCKED
//   err      one-cycle pulse on a mismatch detected in LOCKED
//   err_cnt  saturating count of mismatches since reset
//   wrap_up  one-cycle pulse on a checked up-step from all-ones to 0
//   wrap_dn  one-cycle pulse on a checked down-step from 0 to all-ones
module counter_checker #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] cnt_in,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             wrap_up,
    output logic             wrap_dn
);

    typedef enum logic [1:0] {StIdle, StAcquire, StLocked, StError} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q;
    logic             prev_mode_q;
    logic [3:0]       match_q, match_d;

    logic [WIDTH-1:0] exp_cnt;
    logic             hit;
    logic             locked_d, err_d, wrap_up_d, wrap_dn_d;
    logic [ERR_W-1:0] err_cnt_d;

    // The previous mode is the direction that produced the current sample, so a
    // mode change is reflected in the prediction one cycle later.
    assign exp_cnt = prev_mode_q ? prev_q + WIDTH'(1) : prev_q - WIDTH'(1);
    assign hit     = (cnt_in == exp_cnt);

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            prev_q      <= '0;
            prev_mode_q <= 1'b1;
            match_q     <= '0;
            locked      <= 1'b0;
            err         <= 1'b0;
            err_cnt     <= '0;
            wrap_up     <= 1'b0;
            wrap_dn     <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            if (en) begin
                prev_q      <= cnt_in;
                prev_mode_q <= mode;
            end
            locked  <= locked_d;
            err     <= err_d;
            err_cnt <= err_cnt_d;
            wrap_up <= wrap_up_d;
            wrap_dn <= wrap_dn_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        match_d = match_q;
        if (!en) begin
            state_d = StIdle;
            match_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // First active edge only captures; nothing to compare against yet.
                    state_d = StAcquire;
                    match_d = '0;
                end
                StAcquire: begin
                    if (hit) begin
                        if (match_q + 4'd1 == 4'(LOCK_CNT)) begin
                            state_d = StLocked;
                            match_d = '0;
                        end else begin
                            match_d = match_q + 4'd1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                StLocked: begin
                    if (!hit) begin
                        state_d = StError;
                    end
                end
                StError: begin
                    state_d = StAcquire;
                    match_d = '0;
                end
                default: begin
                    state_d = StIdle;
                    match_d = '0;
                end
            endcase
        end
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        locked_d  = (state_d == StLocked);
        err_d     = en && (state_q == StLocked) && !hit;
        wrap_up_d = en && (state_q == StLocked) && hit && prev_mode_q && (&prev_q);
        wrap_dn_d = en && (state_q == StLocked) && hit && !prev_mode_q && !(|prev_q);
        err_cnt_d = err_cnt;
        if (err_d && !(&err_cnt)) begin
            err_cnt_d = err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_counter_checker.sv
// Self-checking bench for counter_checker. Two instances share stimulus:
// one with the default 8-bit error counter, one with a 2-bit counter to
// exercise saturation. A behavioural model tracks expected outputs.
module tb_counter_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b1;
    logic [4:0] cnt_in = '0;

    logic       locked_a, err_a, wrap_up_a, wrap_dn_a;
    logic [7:0] err_cnt_a;
    logic       locked_b, err_b, wrap_up_b, wrap_dn_b;
    logic [1:0] err_cnt_b;

    counter_checker #(.WIDTH(5), .LOCK_CNT(2), .ERR_W(8)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .cnt_in  (cnt_in),
        .locked  (locked_a),
        .err     (err_a),
        .err_cnt (err_cnt_a),
        .wrap_up (wrap_up_a),
        .wrap_dn (wrap_dn_a)
    );

    counter_checker #(.WIDTH(5), .LOCK_CNT(2), .ERR_W(2)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .cnt_in  (cnt_in),
        .locked  (locked_b),
        .err     (err_b),
        .err_cnt (err_cnt_b),
        .wrap_up (wrap_up_b),
        .wrap_dn (wrap_dn_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: tracks whether we have a previous sample, whether
    // the last edge was a mismatch (recovery edge), lock status and streak.
    bit m_have_prev, m_recover, m_locked, m_err, m_wu, m_wd, m_pm;
    int m_pc, m_streak, m_ecnt_a, m_ecnt_b;

    task automatic model_reset();
        m_have_prev = 0; m_recover = 0; m_locked = 0;
        m_err = 0; m_wu = 0; m_wd = 0; m_pm = 1;
        m_pc = 0; m_streak = 0; m_ecnt_a = 0; m_ecnt_b = 0;
    endtask

    task automatic model_edge(input bit e, input bit md, input int c);
        int predicted;
        m_err = 0; m_wu = 0; m_wd = 0;
        if (!e) begin
            m_have_prev = 0; m_recover = 0; m_locked = 0; m_streak = 0;
        end else begin
            predicted = m_pm ? (m_pc + 1) % 32 : (m_pc + 31) % 32;
            if (!m_have_prev || m_recover) begin
                m_have_prev = 1; m_recover = 0; m_streak = 0;
            end else if (m_locked) begin
                if (c == predicted) begin
                    m_wu = m_pm && (m_pc == 31);
                    m_wd = !m_pm && (m_pc == 0);
                end else begin
                    m_err = 1;
                    if (m_ecnt_a < 255) m_ecnt_a++;
                    if (m_ecnt_b < 3) m_ecnt_b++;
                    m_locked = 0;
                    m_recover = 1;
                end
            end else if (c == predicted) begin
                m_streak++;
                if (m_streak == 2) begin
                    m_locked = 1;
                    m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
            m_pc = c;
            m_pm = md;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".locked_a"},  int'(locked_a),  int'(m_locked));
        check({tag, ".err_a"},     int'(err_a),     int'(m_err));
        check({tag, ".err_cnt_a"}, int'(err_cnt_a), m_ecnt_a);
        check({tag, ".wrap_up_a"}, int'(wrap_up_a), int'(m_wu));
        check({tag, ".wrap_dn_a"}, int'(wrap_dn_a), int'(m_wd));
        check({tag, ".locked_b"},  int'(locked_b),  int'(m_locked));
        check({tag, ".err_b"},     int'(err_b),     int'(m_err));
        check({tag, ".err_cnt_b"}, int'(err_cnt_b), m_ecnt_b);
        check({tag, ".wrap_up_b"}, int'(wrap_up_b), int'(m_wu));
        check({tag, ".wrap_dn_b"}, int'(wrap_dn_b), int'(m_wd));
    endtask

    int n_wu, n_wd, n_err_a, n_err_b;

    // Drive one cycle of stimulus, advance the model at the edge, compare 1 ns later.
    task automatic step(input string tag, input bit e, input bit md, input int c);
        en = e; mode = md; cnt_in = 5'(c);
        @(posedge clk);
        model_edge(e, md, c & 31);
        #1;
        check_model(tag);
        n_wu    += int'(wrap_up_a);
        n_wd    += int'(wrap_dn_a);
        n_err_a += int'(err_a);
        n_err_b += int'(err_b);
    endtask

    task automatic clear_tallies();
        n_wu = 0; n_wd = 0; n_err_a = 0; n_err_b = 0;
    endtask

    initial begin
        int v;
        int tv;
        bit tm;
        int sat_exp[4];
        int m9[8];
        int v9[8];
        sat_exp = '{1, 2, 3, 3};
        v9 = '{8, 9, 10, 11, 12, 11, 10, 9};
        m9 = '{1, 1, 1, 1, 0, 0, 0, 0};

        model_reset();
        #2;
        check_model("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Up count through a wrap
        clear_tallies();
        for (int i = 0; i < 33; i++) begin
            step("up", 1, 1, i % 32);
            if (i == 1) check("up.unlocked_after_edge2", int'(locked_a), 0);
            if (i == 2) check("up.locked_after_edge3", int'(locked_a), 1);
        end
        check("up.wrap_up_pulses", n_wu, 1);
        check("up.err_pulses", n_err_a, 0);

        // Down count through a wrap
        step("idle", 0, 1, 0);
        clear_tallies();
        for (int i = 0; i < 10; i++) step("down", 1, 0, (5 - i + 32) % 32);
        check("down.wrap_dn_pulses", n_wd, 1);
        check("down.wrap_up_pulses", n_wu, 0);
        check("down.err_pulses", n_err_a, 0);

        // Mode flip while locked
        step("idle", 0, 1, 0);
        clear_tallies();
        for (int i = 0; i < 8; i++) step("flip", 1, m9[i][0], v9[i]);
        check("flip.locked", int'(locked_a), 1);
        check("flip.err_pulses", n_err_a, 0);

        // Injected glitch while locked
        step("idle", 0, 1, 0);
        clear_tallies();
        for (int i = 3; i <= 6; i++) step("glitch", 1, 1, i);
        step("glitch", 1, 1, 9);
        check("glitch.err", int'(err_a), 1);
        check("glitch.locked", int'(locked_a), 0);
        check("glitch.err_cnt", int'(err_cnt_a), 1);
        step("glitch", 1, 1, 10);
        check("glitch.err_one_cycle", int'(err_a), 0);
        step("glitch", 1, 1, 11);
        step("glitch", 1, 1, 12);
        check("glitch.relocked", int'(locked_a), 1);
        step("glitch", 1, 1, 13);
        check("glitch.err_pulses", n_err_a, 1);

        // Asynchronous reset mid-count, no clock edge needed
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("arst.locked", int'(locked_a), 0);
        check("arst.err_cnt", int'(err_cnt_a), 0);
        check_model("arst");
        #2;
        rst = 1'b1;
        step("arst", 1, 1, 14);
        step("arst", 1, 1, 15);
        check("arst.not_yet_locked", int'(locked_a), 0);
        step("arst", 1, 1, 16);
        check("arst.relocked", int'(locked_a), 1);

        // Saturation of the 2-bit counter: four mismatches, each after a relock
        step("idle", 0, 1, 0);
        clear_tallies();
        v = 0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) step("sat", 1, 1, (v + j) & 31);
            step("sat", 1, 1, (v + 10) & 31);
            check("sat.err_cnt_b", int'(err_cnt_b), sat_exp[k]);
            check("sat.err_b", int'(err_b), 1);
            v = v + 11;
        end
        check("sat.err_pulses_b", n_err_b, 4);
        check("sat.err_cnt_a", int'(err_cnt_a), 4);

        // Randomised traffic: a true counter with random mode flips, glitches and idles
        tv = int'($urandom_range(31));
        tm = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(99));
            if (r < 4) begin
                step("rand", 0, tm, int'($urandom_range(31)));
                tv = int'($urandom_range(31));
            end else begin
                if (r < 7) tv = int'($urandom_range(31));
                if (r >= 7 && r < 14) tm = ~tm;
                step("rand", 1, tm, tv);
                tv = tm ? (tv + 1) % 32 : (tv + 31) % 32;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
